// File: rtl/cpu_fetch_pkg.sv
// Shared encodings and defaults for the instruction fetch unit.
// The state values are fixed because they appear in debug views of the FSM.
package cpu_fetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        HOLD  = ST_HOLD,
        DRAIN = ST_DRAIN
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/mux2x1.sv
// Two-input word multiplexer: sel=0 passes a, sel=1 passes b.
module mux2x1 #(
    parameter int unsigned n = 32
) (
    input  logic         sel,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch over a req/ack memory handshake.
// Define FETCH_PERF_EN to add the fetched/killed instruction counters.
//
// state | meaning
// IDLE  | no request; launch a fetch at fetch_pc next cycle
// FETCH | request outstanding at imem_addr_o
// HOLD  | instruction presented to decode, waiting for ready
// DRAIN | stale request after a redirect; its data will be dropped
module pc_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned   n        = 32,
    parameter logic [n-1:0]  RESET_PC = n'(DEFAULT_RESET_PC),
    parameter int unsigned   PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         redirect_i,
    input  logic [n-1:0] redirect_target_i,
    output logic         imem_req_o,
    output logic [n-1:0] imem_addr_o,
    input  logic         imem_ack_i,
    input  logic [n-1:0] imem_rdata_i,
    output logic         instr_valid_o,
    input  logic         instr_ready_i,
    output logic [n-1:0] instr_o,
    output logic [n-1:0] pc_o,
`ifdef FETCH_PERF_EN
    output logic [n-1:0] fetched_cnt_o,
    output logic [n-1:0] killed_cnt_o,
`endif
    output logic [n-1:0] pc_plus4_o
);

    localparam logic [n-1:0] STEP = n'(PC_STEP);

    fetch_state_e state;
    fetch_state_e state_next;

    logic [n-1:0] fetch_pc;
    logic [n-1:0] fetch_pc_inc;
    logic [n-1:0] fetch_pc_next;
    logic         fetch_pc_load;
    logic [n-1:0] addr_next;
    logic         addr_load;
    logic         capture;
    logic         valid_next;

    assign fetch_pc_inc = fetch_pc + STEP;
    assign pc_plus4_o   = pc_o + STEP;

    mux2x1 #(.n(n)) u_pc_mux (
        .sel (redirect_i),
        .a   (fetch_pc_inc),
        .b   (redirect_target_i),
        .y   (fetch_pc_next)
    );

    always_comb begin
        state_next    = state;
        imem_req_o    = 1'b0;
        fetch_pc_load = redirect_i;
        addr_load     = 1'b0;
        addr_next     = fetch_pc;
        capture       = 1'b0;
        valid_next    = instr_valid_o;

        case (state)
            IDLE: begin
                // A redirect arriving here is already the address we want.
                addr_load  = 1'b1;
                addr_next  = redirect_i ? redirect_target_i : fetch_pc;
                state_next = FETCH;
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    fetch_pc_load = 1'b1;
                    if (redirect_i) begin
                        state_next = IDLE;
                    end else begin
                        capture    = 1'b1;
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end
                end else if (redirect_i) begin
                    state_next = DRAIN;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end else if (instr_ready_i) begin
                    valid_next = 1'b0;
                    addr_load  = 1'b1;
                    addr_next  = fetch_pc;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    addr_load  = 1'b1;
                    addr_next  = redirect_i ? redirect_target_i : fetch_pc;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            imem_addr_o   <= '0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            pc_o          <= RESET_PC;
        end else begin
            state         <= state_next;
            instr_valid_o <= valid_next;
            if (fetch_pc_load) fetch_pc <= fetch_pc_next;
            if (addr_load) imem_addr_o <= addr_next;
            if (capture) begin
                instr_o <= imem_rdata_i;
                pc_o    <= imem_addr_o;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic xfer_evt;
    logic kill_evt;

    // A HOLD redirect kills the instruction even when decode is ready.
    assign xfer_evt = (state == HOLD) && instr_ready_i && !redirect_i;
    assign kill_evt = ((state == FETCH) && imem_ack_i && redirect_i) ||
                      ((state == HOLD)  && redirect_i) ||
                      ((state == DRAIN) && imem_ack_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_cnt_o <= '0;
            killed_cnt_o  <= '0;
        end else begin
            if (xfer_evt) fetched_cnt_o <= fetched_cnt_o + 1'b1;
            if (kill_evt) killed_cnt_o  <= killed_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected (pc, instr) pairs are queued
// when a fetch is launched and compared when decode accepts the instruction.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] fetched_cnt;
    logic [31:0] killed_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    pc_fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_i        (redirect),
        .redirect_target_i (target),
        .imem_req_o        (req),
        .imem_addr_o       (addr),
        .imem_ack_i        (ack),
        .imem_rdata_i      (rdata),
        .instr_valid_o     (valid),
        .instr_ready_i     (ready),
        .instr_o           (instr),
        .pc_o              (pc),
`ifdef FETCH_PERF_EN
        .fetched_cnt_o     (fetched_cnt),
        .killed_cnt_o      (killed_cnt),
`endif
        .pc_plus4_o        (pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic exp_t mk(input logic [31:0] p);
        exp_t e;
        e.pc    = p;
        e.instr = mem_word(p);
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; redirect = 1'b0; ack = 1'b0; ready = 1'b0;
        target = '0; rdata = '0;
        tick; tick;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset;
        do_reset;
        rst_n = 1'b0;
        tick;
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %0b want 0", req); end
        n_cmp++; if (addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_cmp++; if (pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
`ifdef FETCH_PERF_EN
        n_cmp++; if (fetched_cnt !== 0 || killed_cnt !== 0) begin
            n_bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", fetched_cnt, killed_cnt);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        exp_t e;
        int got = 0;
        int last = -1;
        do_reset;
        ready = 1'b1;
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        exp_q.push_back(mk(32'h8));
        exp_q.push_back(mk(32'hC));
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL stream_extra: got pc %h want none", pc);
                end else begin
                    e = exp_q.pop_front();
                    if (pc !== e.pc || instr !== e.instr || pc_plus4 !== e.pc + 32'd4) begin
                        n_bad++;
                        $display("FAIL stream_data: got pc %h instr %h p4 %h want pc %h instr %h p4 %h",
                                 pc, instr, pc_plus4, e.pc, e.instr, e.pc + 32'd4);
                    end
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != 2) begin n_bad++; $display("FAIL stream_gap: got %0d want 2", c - last); end
                end
                last = c;
                got++;
            end
            ack = req;
            rdata = mem_word(addr);
            tick;
        end
        ack = 1'b0;
        n_cmp++; if (got != 4) begin n_bad++; $display("FAIL stream_count: got %0d want 4", got); end
`ifdef FETCH_PERF_EN
        n_cmp++; if (fetched_cnt !== 32'd4) begin n_bad++; $display("FAIL stream_fetched_cnt: got %0d want 4", fetched_cnt); end
`endif
    endtask

    task automatic test_delay;
        exp_t e;
        do_reset;
        ready = 1'b1;
        exp_q.push_back(mk(32'h0));
        tick;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin
                n_bad++; $display("FAIL delay_wait%0d: got req %0b addr %h valid %0b want 1 0 0", k, req, addr, valid);
            end
            tick;
        end
        ack = 1'b1; rdata = mem_word(32'h0);
        tick;
        ack = 1'b0;
        n_cmp++;
        if (valid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL delay_valid: got %0b want 1", valid);
        end else begin
            e = exp_q.pop_front();
            if (pc !== e.pc || instr !== e.instr) begin
                n_bad++; $display("FAIL delay_data: got %h/%h want %h/%h", pc, instr, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_hold;
        exp_t e;
        do_reset;
        tick;
        ack = 1'b1; rdata = mem_word(32'h0);
        tick;
        // Stray acks while holding must not disturb the presented instruction.
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (valid !== 1'b1 || req !== 1'b0 || pc !== 32'h0 || instr !== mem_word(32'h0)) begin
                n_bad++;
                $display("FAIL hold_stable%0d: got v %0b req %0b pc %h instr %h want 1 0 0 %h",
                         k, valid, req, pc, instr, mem_word(32'h0));
            end
            tick;
        end
        ack = 1'b0;
        exp_q.push_back(mk(32'h0));
        ready = 1'b1;
        n_cmp++;
        if (valid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL hold_xfer: got valid %0b want 1", valid);
        end else begin
            e = exp_q.pop_front();
            if (pc !== e.pc || instr !== e.instr) begin
                n_bad++; $display("FAIL hold_data: got %h/%h want %h/%h", pc, instr, e.pc, e.instr);
            end
        end
        tick;
        n_cmp++;
        if (req !== 1'b1 || addr !== 32'h4 || valid !== 1'b0) begin
            n_bad++; $display("FAIL hold_next: got req %0b addr %h valid %0b want 1 4 0", req, addr, valid);
        end
    endtask

    task automatic test_drain;
        exp_t e;
        bit reached = 1'b0;
        do_reset;
        ready = 1'b1;
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        for (int c = 0; c < 20; c++) begin
            if (req && addr == 32'h8) begin reached = 1'b1; break; end
            if (valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (pc !== e.pc || instr !== e.instr) begin
                    n_bad++; $display("FAIL drain_pre: got %h/%h want %h/%h", pc, instr, e.pc, e.instr);
                end
            end
            ack = req; rdata = mem_word(addr);
            tick;
        end
        ack = 1'b0;
        n_cmp++; if (!reached || exp_q.size() != 0) begin
            n_bad++; $display("FAIL drain_reach: got reached %0b left %0d want 1 0", reached, exp_q.size());
        end
        redirect = 1'b1; target = 32'h100;
        tick;
        redirect = 1'b0;
        n_cmp++;
        if (req !== 1'b1 || addr !== 32'h8 || valid !== 1'b0) begin
            n_bad++; $display("FAIL drain_hold: got req %0b addr %h valid %0b want 1 8 0", req, addr, valid);
        end
        tick;
        n_cmp++; if (addr !== 32'h8 || req !== 1'b1) begin
            n_bad++; $display("FAIL drain_stable: got req %0b addr %h want 1 8", req, addr);
        end
        ack = 1'b1; rdata = mem_word(32'h8);
        tick;
        ack = 1'b0;
        n_cmp++;
        if (req !== 1'b1 || addr !== 32'h100 || valid !== 1'b0) begin
            n_bad++; $display("FAIL drain_redir: got req %0b addr %h valid %0b want 1 100 0", req, addr, valid);
        end
`ifdef FETCH_PERF_EN
        n_cmp++; if (killed_cnt !== 32'd1) begin n_bad++; $display("FAIL drain_killed_cnt: got %0d want 1", killed_cnt); end
`endif
        exp_q.push_back(mk(32'h100));
        ack = 1'b1; rdata = mem_word(32'h100);
        tick;
        ack = 1'b0;
        n_cmp++;
        if (valid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++; $display("FAIL drain_valid: got %0b want 1", valid);
        end else begin
            e = exp_q.pop_front();
            if (pc !== e.pc || instr !== e.instr) begin
                n_bad++; $display("FAIL drain_data: got %h/%h want %h/%h", pc, instr, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_kill;
        do_reset;
        ready = 1'b1;
        tick;
        ack = 1'b1; rdata = mem_word(32'h0); redirect = 1'b1; target = 32'h40;
        tick;
        ack = 1'b0; redirect = 1'b0;
        n_cmp++; if (valid !== 1'b0 || req !== 1'b0) begin
            n_bad++; $display("FAIL kill_ack: got valid %0b req %0b want 0 0", valid, req);
        end
`ifdef FETCH_PERF_EN
        n_cmp++; if (killed_cnt !== 32'd1) begin n_bad++; $display("FAIL kill_cnt1: got %0d want 1", killed_cnt); end
`endif
        tick;
        n_cmp++; if (req !== 1'b1 || addr !== 32'h40) begin
            n_bad++; $display("FAIL kill_addr1: got req %0b addr %h want 1 40", req, addr);
        end
        ack = 1'b1; rdata = mem_word(32'h40);
        tick;
        ack = 1'b0;
        n_cmp++; if (valid !== 1'b1 || pc !== 32'h40 || instr !== mem_word(32'h40)) begin
            n_bad++; $display("FAIL kill_fetch: got v %0b pc %h instr %h want 1 40 %h", valid, pc, instr, mem_word(32'h40));
        end
        redirect = 1'b1; target = 32'h40;
        tick;
        redirect = 1'b0;
        n_cmp++; if (valid !== 1'b0 || req !== 1'b0) begin
            n_bad++; $display("FAIL kill_hold: got valid %0b req %0b want 0 0", valid, req);
        end
`ifdef FETCH_PERF_EN
        n_cmp++; if (killed_cnt !== 32'd2 || fetched_cnt !== 32'd0) begin
            n_bad++; $display("FAIL kill_cnt2: got killed %0d fetched %0d want 2 0", killed_cnt, fetched_cnt);
        end
`endif
        tick;
        n_cmp++; if (req !== 1'b1 || addr !== 32'h40) begin
            n_bad++; $display("FAIL kill_addr2: got req %0b addr %h want 1 40", req, addr);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        ready = 1'b1;
        tick;
        ack = 1'b1; redirect = 1'b1; target = 32'hFFFF_FFFC;
        tick;
        ack = 1'b0; redirect = 1'b0;
        tick;
        n_cmp++; if (addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr: got %h want fffffffc", addr); end
        ack = 1'b1; rdata = mem_word(32'hFFFF_FFFC);
        tick;
        ack = 1'b0;
        n_cmp++; if (valid !== 1'b1 || pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            n_bad++; $display("FAIL wrap_pc: got v %0b pc %h p4 %h want 1 fffffffc 0", valid, pc, pc_plus4);
        end
        tick;
        n_cmp++; if (req !== 1'b1 || addr !== 32'h0) begin
            n_bad++; $display("FAIL wrap_next: got req %0b addr %h want 1 0", req, addr);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        ready = 1'b1;
        tick;
        ack = 1'b1; rdata = mem_word(32'h0); tick;
        ack = 1'b0; tick;
        ack = 1'b1; rdata = mem_word(32'h4); tick;
        ack = 1'b0; tick;
        n_cmp++; if (req !== 1'b1 || addr !== 32'h8 || pc !== 32'h4) begin
            n_bad++; $display("FAIL rmid_pre: got req %0b addr %h pc %h want 1 8 4", req, addr, pc);
        end
        rst_n = 1'b0;
        tick;
        n_cmp++; if (req !== 1'b0 || valid !== 1'b0 || pc !== 32'h0 || addr !== 32'h0) begin
            n_bad++; $display("FAIL rmid_reset: got req %0b valid %0b pc %h addr %h want 0 0 0 0", req, valid, pc, addr);
        end
        rst_n = 1'b1;
        ack = 1'b1; rdata = 32'hBAD0_BAD0;
        tick;
        ack = 1'b0;
        n_cmp++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h0 || instr !== 32'h0) begin
            n_bad++; $display("FAIL rmid_late_ack: got v %0b req %0b addr %h instr %h want 0 1 0 0", valid, req, addr, instr);
        end
        ack = 1'b1; rdata = mem_word(32'h0);
        tick;
        ack = 1'b0;
        n_cmp++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            n_bad++; $display("FAIL rmid_refetch: got v %0b pc %h instr %h want 1 0 %h", valid, pc, instr, mem_word(32'h0));
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_delay;
        test_hold;
        test_drain;
        test_kill;
        test_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
